// File: rtl/router_pkt_ctrl_if.sv
// Bus bundle between the packet source, the router ingress controller and the three output FIFOs.
// The master modport is the environment (source, FIFO flags, readers). The slave modport is the controller.
// Ports: pkt_valid/data_in/busy (source), data_out/write_enb/lfd_state (FIFO write),
//        fifo_full/fifo_empty/read_enb (FIFO status), vld_out/soft_reset/err (status out).
interface router_pkt_ctrl_if;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       busy;
    logic [7:0] data_out;
    logic [2:0] write_enb;
    logic       lfd_state;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] read_enb;
    logic [2:0] vld_out;
    logic [2:0] soft_reset;
    logic       err;

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
        input  busy, data_out, write_enb, lfd_state, vld_out, soft_reset, err
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
        output busy, data_out, write_enb, lfd_state, vld_out, soft_reset, err
    );
endinterface

// File: rtl/router_pkt_ctrl.sv
// Ingress sequencer of the 1x3 router: decodes headers and steers packet bytes into one of three FIFOs.
// Latency: an accepted byte is written to its FIFO one cycle later; write_enb/lfd_state are combinational from the data register.
// Backpressure: busy holds the source while the selected FIFO is full, while waiting for an empty FIFO, and during DRAIN.
// Ports: clk, reset (sync, active high), bus (router_pkt_ctrl_if.slave).
// Optional feature: define PARITY_CHECK_EN to build the parity checker that drives err; otherwise err is tied low.
module router_pkt_ctrl #(
    parameter int TIMEOUT = 30
) (
    input  logic              clk,
    input  logic              reset,
    router_pkt_ctrl_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, WAIT_EMPTY, XFER, DRAIN, DROP} state_t;

    state_t     state_q, state_d;
    logic [7:0] data_q, data_d;
    logic       dvalid_q, dvalid_d;
    logic       dhdr_q, dhdr_d;
    logic [1:0] sel_q, sel_d;
    logic [6:0] cnt_q, cnt_d;
    logic       busy;
    logic [2:0] srst;

    logic [1:0] dest;
    logic [6:0] len_p1;
    logic       sel_full;
    logic       sel_srst;
    logic       write_fire;

    assign dest       = bus.data_in[1:0];
    assign len_p1     = {1'b0, bus.data_in[7:2]} + 7'd1;
    assign sel_full   = bus.fifo_full[sel_q];
    assign sel_srst   = srst[sel_q];
    // A soft reset on the selected FIFO wins over a pending write.
    assign write_fire = dvalid_q && !sel_full && !sel_srst;

    // Idle timers: a FIFO that holds data but is not read for TIMEOUT cycles is soft-reset.
    for (genvar i = 0; i < 3; i++) begin : g_timer
        logic [TW-1:0] timer_q;
        assign srst[i] = !bus.fifo_empty[i] && !bus.read_enb[i] && (timer_q == TW'(TIMEOUT - 1));
        always_ff @(posedge clk) begin
            if (reset)
                timer_q <= '0;
            else if (bus.fifo_empty[i] || bus.read_enb[i] || srst[i])
                timer_q <= '0;
            else
                timer_q <= timer_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            data_q   <= '0;
            dvalid_q <= 1'b0;
            dhdr_q   <= 1'b0;
            sel_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            dvalid_q <= dvalid_d;
            dhdr_q   <= dhdr_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        dvalid_d = dvalid_q;
        dhdr_d   = dhdr_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        busy     = 1'b0;
        if (write_fire)
            dvalid_d = 1'b0;
        case (state_q)
            IDLE: begin
                busy = bus.pkt_valid && (dest != 2'd3) && !bus.fifo_empty[dest];
                if (bus.pkt_valid) begin
                    if (dest == 2'd3) begin
                        cnt_d   = len_p1;
                        state_d = DROP;
                    end else if (bus.fifo_empty[dest]) begin
                        data_d   = bus.data_in;
                        dvalid_d = 1'b1;
                        dhdr_d   = 1'b1;
                        sel_d    = dest;
                        cnt_d    = len_p1;
                        state_d  = XFER;
                    end else begin
                        // Header is left on data_in and decoded again once the FIFO empties.
                        sel_d   = dest;
                        state_d = WAIT_EMPTY;
                    end
                end
            end
            WAIT_EMPTY: begin
                busy = 1'b1;
                if (bus.fifo_empty[sel_q])
                    state_d = IDLE;
            end
            XFER: begin
                busy = dvalid_q && sel_full;
                if (sel_srst) begin
                    // The FIFO is being flushed: the rest of the packet is consumed unwritten.
                    dvalid_d = 1'b0;
                    state_d  = DROP;
                    if (bus.pkt_valid && !busy) begin
                        cnt_d = cnt_q - 7'd1;
                        if (cnt_q == 7'd1)
                            state_d = IDLE;
                    end
                end else if (bus.pkt_valid && !busy) begin
                    data_d   = bus.data_in;
                    dvalid_d = 1'b1;
                    dhdr_d   = 1'b0;
                    cnt_d    = cnt_q - 7'd1;
                    if (cnt_q == 7'd1)
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (sel_srst) begin
                    dvalid_d = 1'b0;
                    state_d  = IDLE;
                end else if (!dvalid_q || write_fire) begin
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (bus.pkt_valid) begin
                    cnt_d = cnt_q - 7'd1;
                    if (cnt_q == 7'd1)
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy       = busy;
    assign bus.data_out   = data_q;
    assign bus.write_enb  = write_fire ? (3'b001 << sel_q) : 3'b000;
    assign bus.lfd_state  = write_fire && dhdr_q;
    assign bus.vld_out    = ~bus.fifo_empty;
    assign bus.soft_reset = srst;

`ifdef PARITY_CHECK_EN
    logic [7:0] xor_q;
    logic       err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            xor_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (state_q == IDLE && state_d == XFER) begin
                xor_q <= bus.data_in;
            end else if (state_q == XFER && bus.pkt_valid && !busy && !sel_srst) begin
                if (cnt_q == 7'd1)
                    err_q <= (bus.data_in != xor_q);
                else
                    xor_q <= xor_q ^ bus.data_in;
            end
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_router_pkt_ctrl.sv
module tb_router_pkt_ctrl;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    router_pkt_ctrl_if bus();

    router_pkt_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int err_cnt = 0;
    int srst_cnt = 0;
    int last_wait = 0;
    int cyc = 0;
    int occ[3];
    bit env_auto = 1'b0;

    logic       s_busy, s_lfd, s_err;
    logic [2:0] s_wen, s_srst, s_vld;
    logic [7:0] s_dout;

    // Each entry: {fifo index, lfd, byte}
    logic [10:0] wr_q[$];
    logic [10:0] exp_q[$];
    logic [7:0]  pkt_q[$];

    // One clock: sample outputs on the falling edge, record writes, update the FIFO occupancy
    // model, then step past the rising edge and apply new inputs.
    task automatic cycle();
        logic [1:0] p;
        @(negedge clk);
        s_busy = bus.busy;
        s_wen  = bus.write_enb;
        s_lfd  = bus.lfd_state;
        s_dout = bus.data_out;
        s_srst = bus.soft_reset;
        s_err  = bus.err;
        s_vld  = bus.vld_out;
        if (!reset && s_wen != 3'b000) begin
            p = (s_wen == 3'b001) ? 2'd0 : (s_wen == 3'b010) ? 2'd1 : (s_wen == 3'b100) ? 2'd2 : 2'd3;
            wr_q.push_back({p, s_lfd, s_dout});
        end
        if (!reset && s_err === 1'b1) err_cnt++;
        if (!reset && s_srst != 3'b000) srst_cnt += $countones(s_srst);
        if (env_auto) begin
            for (int i = 0; i < 3; i++) begin
                if (s_srst[i]) occ[i] = 0;
                else begin
                    if (bus.read_enb[i] && occ[i] > 0) occ[i]--;
                    if (s_wen[i]) occ[i]++;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (env_auto) begin
            for (int i = 0; i < 3; i++) begin
                bus.read_enb[i]   = ($urandom_range(0, 1) == 1) || (cyc % 8 == 0);
                bus.fifo_empty[i] = (occ[i] == 0);
                bus.fifo_full[i]  = (occ[i] >= DEPTH);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        bus.pkt_valid = 1'b1;
        bus.data_in   = b;
        for (k = 0; k < 400; k++) begin
            cycle();
            if (s_busy === 1'b0) break;
        end
        last_wait = k + 1;
        n_cmp++;
        if (k == 400) begin
            n_fail++;
            $display("FAIL send_timeout byte=%02h still busy after %0d cycles", b, k);
        end
        bus.pkt_valid = 1'b0;
    endtask

    task automatic send_pkt();
        foreach (pkt_q[k]) send_byte(pkt_q[k]);
    endtask

    // Reference packet builder: header {len,dest}, random payload, parity = XOR of all prior bytes.
    task automatic build_pkt(input int dest, input int len, input bit bad);
        logic [7:0] h, x, b;
        logic [5:0] l;
        logic [1:0] d;
        l = len[5:0];
        d = dest[1:0];
        h = {l, d};
        pkt_q.delete();
        pkt_q.push_back(h);
        x = h;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            pkt_q.push_back(b);
            x = x ^ b;
        end
        pkt_q.push_back(bad ? (x ^ 8'($urandom_range(1, 255))) : x);
    endtask

    task automatic expect_pkt();
        logic [7:0] h;
        h = pkt_q[0];
        if (h[1:0] != 2'd3)
            foreach (pkt_q[k]) exp_q.push_back({h[1:0], (k == 0), pkt_q[k]});
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        n_cmp++; if (s_busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got=%b want=0", s_busy); end
        n_cmp++; if (s_dout !== 8'h00)  begin n_fail++; $display("FAIL reset_data_out got=%02h want=00", s_dout); end
        n_cmp++; if (s_wen !== 3'b000)  begin n_fail++; $display("FAIL reset_write_enb got=%b want=000", s_wen); end
        n_cmp++; if (s_lfd !== 1'b0)    begin n_fail++; $display("FAIL reset_lfd got=%b want=0", s_lfd); end
        n_cmp++; if (s_srst !== 3'b000) begin n_fail++; $display("FAIL reset_soft_reset got=%b want=000", s_srst); end
        n_cmp++; if (s_err !== 1'b0)    begin n_fail++; $display("FAIL reset_err got=%b want=0", s_err); end
        reset = 1'b0;
    endtask

    task automatic test_vld_out();
        logic [2:0] e;
        for (int i = 0; i < 4; i++) begin
            e = 3'($urandom);
            bus.fifo_empty = e;
            cycle();
            n_cmp++;
            if (s_vld !== ~e) begin n_fail++; $display("FAIL vld_out got=%b want=%b", s_vld, ~e); end
        end
        bus.fifo_empty = 3'b111;
        cycle();
    endtask

    task automatic test_reset_mid();
        send_byte(8'h0D);
        send_byte(8'hA1);
        bus.pkt_valid = 1'b1;
        bus.data_in   = 8'hB2;
        reset = 1'b1;
        cycle();
        cycle();
        n_cmp++;
        if ({s_busy, s_dout, s_wen, s_lfd, s_srst, s_err} !== 16'h0)
            begin n_fail++; $display("FAIL midreset_outputs got busy=%b dout=%02h wen=%b lfd=%b srst=%b err=%b want all 0",
                                     s_busy, s_dout, s_wen, s_lfd, s_srst, s_err); end
        reset = 1'b0;
        bus.pkt_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_cmp++;
            if (s_wen !== 3'b000 || s_busy !== 1'b0)
                begin n_fail++; $display("FAIL midreset_after wen=%b busy=%b want 000/0", s_wen, s_busy); end
        end
        wr_q.delete();
    endtask

    task automatic test_basic();
        logic [2:0] ew;
        pkt_q = '{8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'h00};
        pkt_q[4] = pkt_q[0] ^ pkt_q[1] ^ pkt_q[2] ^ pkt_q[3];
        for (int j = 0; j < 7; j++) begin
            bus.pkt_valid = (j < 5);
            bus.data_in   = (j < 5) ? pkt_q[j] : 8'h00;
            cycle();
            ew = (j >= 1 && j <= 5) ? 3'b010 : 3'b000;
            n_cmp++; if (s_wen !== ew) begin n_fail++; $display("FAIL basic_wen cyc%0d got=%b want=%b", j, s_wen, ew); end
            n_cmp++; if (s_lfd !== (j == 1)) begin n_fail++; $display("FAIL basic_lfd cyc%0d got=%b want=%b", j, s_lfd, (j == 1)); end
            n_cmp++; if (s_busy !== (j == 5)) begin n_fail++; $display("FAIL basic_busy cyc%0d got=%b want=%b", j, s_busy, (j == 5)); end
            if (j >= 1 && j <= 5) begin
                n_cmp++;
                if (s_dout !== pkt_q[j-1]) begin n_fail++; $display("FAIL basic_dout cyc%0d got=%02h want=%02h", j, s_dout, pkt_q[j-1]); end
            end
            n_cmp++; if (s_err !== 1'b0) begin n_fail++; $display("FAIL basic_err cyc%0d got=%b want=0", j, s_err); end
        end
        bus.pkt_valid = 1'b0;
        wr_q.delete();
    endtask

    task automatic test_backpressure();
        int idx;
        wr_q.delete(); exp_q.delete();
        pkt_q = '{8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'h00};
        pkt_q[4] = pkt_q[0] ^ pkt_q[1] ^ pkt_q[2] ^ pkt_q[3];
        expect_pkt();
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            bus.fifo_full = (c >= 2 && c <= 4) ? 3'b010 : 3'b000;
            bus.pkt_valid = (idx < 5);
            bus.data_in   = (idx < 5) ? pkt_q[idx] : 8'h00;
            cycle();
            if (c >= 2 && c <= 4) begin
                n_cmp++;
                if (s_busy !== 1'b1 || s_wen !== 3'b000 || s_dout !== 8'hA1)
                    begin n_fail++; $display("FAIL bp_hold cyc%0d busy=%b wen=%b dout=%02h want 1/000/a1", c, s_busy, s_wen, s_dout); end
            end
            if (bus.pkt_valid && !s_busy) idx++;
        end
        bus.pkt_valid = 1'b0;
        bus.fifo_full = 3'b000;
        n_cmp++; if (wr_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count got=%0d want=%0d", wr_q.size(), exp_q.size()); end
        for (int k = 0; k < wr_q.size() && k < exp_q.size(); k++) begin
            n_cmp++;
            if (wr_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL bp_write[%0d] got=%03h want=%03h", k, wr_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_wait_empty();
        wr_q.delete(); exp_q.delete();
        build_pkt(2, 2, 1'b0);
        expect_pkt();
        bus.fifo_empty = 3'b011;
        bus.pkt_valid  = 1'b1;
        bus.data_in    = pkt_q[0];
        for (int c = 0; c < 5; c++) begin
            cycle();
            n_cmp++;
            if (s_busy !== 1'b1 || s_wen !== 3'b000)
                begin n_fail++; $display("FAIL wait_hold cyc%0d busy=%b wen=%b want 1/000", c, s_busy, s_wen); end
        end
        bus.fifo_empty = 3'b111;
        send_byte(pkt_q[0]);
        n_cmp++; if (last_wait != 2) begin n_fail++; $display("FAIL wait_accept_cycles got=%0d want=2", last_wait); end
        for (int k = 1; k < pkt_q.size(); k++) send_byte(pkt_q[k]);
        cycle(); cycle();
        n_cmp++; if (wr_q.size() != exp_q.size()) begin n_fail++; $display("FAIL wait_count got=%0d want=%0d", wr_q.size(), exp_q.size()); end
        for (int k = 0; k < wr_q.size() && k < exp_q.size(); k++) begin
            n_cmp++;
            if (wr_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL wait_write[%0d] got=%03h want=%03h", k, wr_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_drop();
        wr_q.delete();
        build_pkt(3, 2, 1'b0);
        for (int j = 0; j < 6; j++) begin
            bus.pkt_valid = (j < 4);
            bus.data_in   = (j < 4) ? pkt_q[j] : 8'h00;
            cycle();
            n_cmp++;
            if (s_wen !== 3'b000 || s_busy !== 1'b0)
                begin n_fail++; $display("FAIL drop_cyc%0d wen=%b busy=%b want 000/0", j, s_wen, s_busy); end
        end
        bus.pkt_valid = 1'b0;
        n_cmp++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL drop_writes got=%0d want=0", wr_q.size()); end
    endtask

    task automatic test_back_to_back();
        wr_q.delete(); exp_q.delete();
        build_pkt(0, 2, 1'b0);
        expect_pkt();
        send_pkt();
        build_pkt(2, 1, 1'b0);
        expect_pkt();
        send_byte(pkt_q[0]);
        n_cmp++; if (last_wait != 2) begin n_fail++; $display("FAIL b2b_header_cycles got=%0d want=2", last_wait); end
        for (int k = 1; k < pkt_q.size(); k++) send_byte(pkt_q[k]);
        cycle(); cycle(); cycle();
        n_cmp++; if (wr_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count got=%0d want=%0d", wr_q.size(), exp_q.size()); end
        for (int k = 0; k < wr_q.size() && k < exp_q.size(); k++) begin
            n_cmp++;
            if (wr_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL b2b_write[%0d] got=%03h want=%03h", k, wr_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_timeout();
        int busy_seen;
        // Idle timer alone: FIFO0 holds data and is never read.
        bus.read_enb   = 3'b000;
        bus.fifo_empty = 3'b110;
        for (int c = 1; c <= 32; c++) begin
            cycle();
            n_cmp++;
            if (s_srst !== ((c == 30) ? 3'b001 : 3'b000))
                begin n_fail++; $display("FAIL timeout_pulse cyc%0d got=%b want=%b", c, s_srst, (c == 30) ? 3'b001 : 3'b000); end
        end
        bus.fifo_empty = 3'b111;
        cycle();
        // Timer expires mid-packet: bytes 0..28 written, byte 29 suppressed, rest consumed unwritten.
        wr_q.delete(); exp_q.delete();
        srst_cnt = 0;
        build_pkt(0, 40, 1'b0);
        for (int k = 0; k < 29; k++) exp_q.push_back({2'd0, (k == 0), pkt_q[k]});
        busy_seen = 0;
        for (int k = 0; k < pkt_q.size(); k++) begin
            bus.pkt_valid = 1'b1;
            bus.data_in   = pkt_q[k];
            cycle();
            if (s_busy !== 1'b0) busy_seen++;
            if (k == 0) bus.fifo_empty = 3'b110;
        end
        bus.pkt_valid  = 1'b0;
        bus.fifo_empty = 3'b111;
        cycle(); cycle();
        n_cmp++; if (busy_seen != 0) begin n_fail++; $display("FAIL tmo_busy cycles=%0d want=0", busy_seen); end
        n_cmp++; if (srst_cnt != 1) begin n_fail++; $display("FAIL tmo_srst_count got=%0d want=1", srst_cnt); end
        n_cmp++; if (wr_q.size() != exp_q.size()) begin n_fail++; $display("FAIL tmo_count got=%0d want=%0d", wr_q.size(), exp_q.size()); end
        for (int k = 0; k < wr_q.size() && k < exp_q.size(); k++) begin
            n_cmp++;
            if (wr_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL tmo_write[%0d] got=%03h want=%03h", k, wr_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_parity();
        logic e;
        pkt_q = '{8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'h00};
        pkt_q[4] = pkt_q[0] ^ pkt_q[1] ^ pkt_q[2] ^ pkt_q[3] ^ 8'h01;
        for (int j = 0; j < 8; j++) begin
            bus.pkt_valid = (j < 5);
            bus.data_in   = (j < 5) ? pkt_q[j] : 8'h00;
            cycle();
`ifdef PARITY_CHECK_EN
            e = (j == 5);
`else
            e = 1'b0;
`endif
            n_cmp++;
            if (s_err !== e) begin n_fail++; $display("FAIL parity_err cyc%0d got=%b want=%b", j, s_err, e); end
        end
        bus.pkt_valid = 1'b0;
        wr_q.delete();
    endtask

    task automatic test_random();
        int exp_err;
        int d;
        bit bad;
        wr_q.delete(); exp_q.delete();
        err_cnt = 0; srst_cnt = 0; exp_err = 0;
        for (int i = 0; i < 3; i++) occ[i] = 0;
        env_auto = 1'b1;
        for (int p = 0; p < 40; p++) begin
            d   = $urandom_range(0, 3);
            bad = ($urandom_range(0, 3) == 0);
            build_pkt(d, $urandom_range(0, 12), bad);
            expect_pkt();
`ifdef PARITY_CHECK_EN
            if (bad && d != 3) exp_err++;
`endif
            send_pkt();
        end
        for (int c = 0; c < 80; c++) cycle();
        env_auto = 1'b0;
        n_cmp++; if (err_cnt != exp_err) begin n_fail++; $display("FAIL rand_err_count got=%0d want=%0d", err_cnt, exp_err); end
        n_cmp++; if (srst_cnt != 0) begin n_fail++; $display("FAIL rand_soft_reset got=%0d want=0", srst_cnt); end
        n_cmp++; if (wr_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count got=%0d want=%0d", wr_q.size(), exp_q.size()); end
        for (int k = 0; k < wr_q.size() && k < exp_q.size(); k++) begin
            n_cmp++;
            if (wr_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rand_write[%0d] got=%03h want=%03h", k, wr_q[k], exp_q[k]); end
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.pkt_valid  = 1'b0;
        bus.data_in    = 8'h00;
        bus.fifo_full  = 3'b000;
        bus.fifo_empty = 3'b111;
        bus.read_enb   = 3'b000;
        test_reset();
        test_vld_out();
        test_reset_mid();
        test_basic();
        test_backpressure();
        test_wait_empty();
        test_drop();
        test_back_to_back();
        test_timeout();
        test_parity();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
